even_parity_framer: RTL and testbench

- Serial transmit controller built around the even-parity generation function.
- Accepts a parallel data word over a valid/ready handshake and shifts it out LSB-first, one bit per clock.
- Appends one even-parity bit so the total count of 1s in each frame (data plus parity) is even.
- Sits between a parallel word source and a 1-bit serial link; sequences the parity datapath frame by frame and enforces an inter-frame gap.

---
 rtl/even_parity_framer.sv | 171 +++++++++++++++++
 tb/tb_even_parity_framer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_parity_framer.sv
// even_parity_framer
// Serial transmit controller: accepts a parallel word over valid/ready,
// shifts it out LSB-first one bit per clock, then appends an even-parity
// bit so each frame (data plus parity) carries an even number of ones.
// A programmable number of idle cycles separates consecutive frames.
// All outputs are registered; the FSM computes next-cycle output values
// alongside the next state.

module even_parity_framer #(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  // Bit counter must hold values 0..DATA_W.
  localparam int CNT_W = $clog2(DATA_W + 1);
  // Gap counter only needs to reach GAP-1; keep at least one bit so the
  // declaration stays legal when GAP is 0 or 1.
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // One step of the running even-parity accumulation.
  function automatic logic parity_step(input logic acc_in, input logic b_in);
    return acc_in ^ b_in;
  endfunction

  state_t            state_r;
  logic [DATA_W-1:0] shreg_r;
  logic              acc_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;

  logic [DATA_W-1:0] shreg_nxt_s;
  logic              acc_nxt_s;

  // Shifted word and parity including the bit currently on the line.
  always_comb begin
    shreg_nxt_s = shreg_r >> 1;
    acc_nxt_s   = parity_step(acc_r, shreg_r[0]);
  end

  // Frame sequencer: state, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shreg_r     <= '0;
      acc_r       <= 1'b0;
      bit_cnt_r   <= '0;
      gap_cnt_r   <= '0;
      in_ready    <= 1'b1;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            // Accept: bit 0 goes on the line in the very next cycle.
            shreg_r     <= in_data;
            acc_r       <= 1'b0;
            bit_cnt_r   <= '0;
            state_r     <= ST_DATA;
            in_ready    <= 1'b0;
            ser_out     <= in_data[0];
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
            busy        <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
            in_ready    <= 1'b1;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            busy        <= 1'b0;
          end
        end

        ST_DATA: begin
          shreg_r     <= shreg_nxt_s;
          acc_r       <= acc_nxt_s;
          bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
          in_ready    <= 1'b0;
          ser_valid   <= 1'b1;
          frame_start <= 1'b0;
          busy        <= 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            // Last data bit is on the line now; parity follows.
            state_r   <= ST_PARITY;
            ser_out   <= acc_nxt_s;
            frame_end <= 1'b1;
          end else begin
            state_r   <= ST_DATA;
            ser_out   <= shreg_nxt_s[0];
            frame_end <= 1'b0;
          end
        end

        ST_PARITY: begin
          frame_cnt   <= frame_cnt + 8'd1;
          ser_out     <= 1'b0;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
          if (GAP > 0) begin
            state_r   <= ST_GAP;
            gap_cnt_r <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        ST_GAP: begin
          ser_out     <= 1'b0;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
          if (gap_cnt_r == GAP_LAST) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state_r   <= ST_GAP;
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          in_ready    <= 1'b1;
          ser_out     <= 1'b0;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_even_parity_framer.sv
// Testbench for even_parity_framer: two instances (8-bit/gap 1 and
// 1-bit/gap 0) checked every cycle against a frame-timeline model, plus
// literal expectations for the directed scenarios.

module tb_even_parity_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       vin   [2];
  logic [7:0] din   [2];
  logic       ser_o [2];
  logic       val_o [2];
  logic       st_o  [2];
  logic       end_o [2];
  logic       busy_o[2];
  logic       rdy_o [2];
  logic [7:0] cnt_o [2];

  always #5 clk = ~clk;

  even_parity_framer #(.DATA_W(8), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(rdy_o[0]),
    .in_data(din[0]), .ser_out(ser_o[0]), .ser_valid(val_o[0]),
    .frame_start(st_o[0]), .frame_end(end_o[0]), .busy(busy_o[0]),
    .frame_cnt(cnt_o[0])
  );

  even_parity_framer #(.DATA_W(1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(rdy_o[1]),
    .in_data(din[1][0:0]), .ser_out(ser_o[1]), .ser_valid(val_o[1]),
    .frame_start(st_o[1]), .frame_end(end_o[1]), .busy(busy_o[1]),
    .frame_cnt(cnt_o[1])
  );

  // Model: per instance, whether a frame is in flight, how many cycles
  // have elapsed since its accept edge, the word, and completed frames.
  int         dw    [2] = '{8, 1};
  int         gp    [2] = '{1, 0};
  logic [7:0] msk   [2] = '{8'hFF, 8'h01};
  bit         m_active[2];
  int         m_age   [2];
  logic [7:0] m_word  [2];
  int         m_cnt   [2];
  bit         acc_flag[2];

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  chk_en = 1'b0;

  logic [8:0] frames_q[$];
  int         starts_q[$];
  logic [7:0] cap_w;
  int         cap_n;
  bit         b_bits[$];
  bit         cap_b_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_dut(input int d);
    logic e_ser, e_val, e_st, e_end, e_busy, e_rdy;
    int k;
    e_ser = 1'b0; e_val = 1'b0; e_st = 1'b0; e_end = 1'b0;
    e_busy = 1'b0; e_rdy = 1'b1;
    if (m_active[d]) begin
      k = m_age[d];
      e_busy = 1'b1;
      e_rdy  = 1'b0;
      if (k < dw[d]) begin
        e_val = 1'b1;
        e_ser = m_word[d][k];
        e_st  = (k == 0);
      end else if (k == dw[d]) begin
        e_val = 1'b1;
        e_ser = ($countones(m_word[d]) % 2) == 1;
        e_end = 1'b1;
      end
    end
    chk($sformatf("ser_out%0d", d),     ser_o[d],  e_ser);
    chk($sformatf("ser_valid%0d", d),   val_o[d],  e_val);
    chk($sformatf("frame_start%0d", d), st_o[d],   e_st);
    chk($sformatf("frame_end%0d", d),   end_o[d],  e_end);
    chk($sformatf("busy%0d", d),        busy_o[d], e_busy);
    chk($sformatf("in_ready%0d", d),    rdy_o[d],  e_rdy);
    chk($sformatf("frame_cnt%0d", d),   cnt_o[d],  m_cnt[d]);
  endtask

  // One clock: advance model at the edge, compare and capture mid-cycle.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      acc_flag[d] = 1'b0;
      if (rst) begin
        m_active[d] = 1'b0;
        m_cnt[d]    = 0;
      end else if (!m_active[d]) begin
        if (vin[d]) begin
          m_active[d] = 1'b1;
          m_age[d]    = 0;
          m_word[d]   = din[d] & msk[d];
          acc_flag[d] = 1'b1;
        end
      end else begin
        if (m_age[d] == dw[d]) m_cnt[d] = (m_cnt[d] + 1) % 256;
        m_age[d]++;
        if (m_age[d] > dw[d] + gp[d]) m_active[d] = 1'b0;
      end
    end
    @(negedge clk);
    if (chk_en) begin
      compare_dut(0);
      compare_dut(1);
    end
    if (val_o[0] === 1'b1) begin
      if (st_o[0] === 1'b1) begin
        cap_n = 0;
        starts_q.push_back(cyc);
      end
      if (end_o[0] === 1'b1) begin
        frames_q.push_back({ser_o[0], cap_w});
      end else if (cap_n < 8) begin
        cap_w[cap_n] = ser_o[0];
        cap_n++;
      end
    end
    if (cap_b_en && val_o[1] === 1'b1) b_bits.push_back(ser_o[1]);
  endtask

  task automatic send(input int d, input logic [7:0] w);
    vin[d] = 1'b1;
    din[d] = w;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc_flag[d]) break;
    end
    chk("accept_timeout", acc_flag[d], 1'b1);
    vin[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 40; i++) begin
      if (!m_active[d]) break;
      step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] t2_words [4];
    logic [8:0] t2_exp   [4];
    logic [7:0] t3_words [3];
    logic [8:0] t3_exp   [3];
    logic [7:0] exp_b;
    int n, fidx, sidx, got, fsz;
    bit nb;

    t2_words = '{8'h07, 8'h00, 8'hFF, 8'h80};
    t2_exp   = '{9'h107, 9'h000, 9'h0FF, 9'h180};
    t3_words = '{8'h01, 8'h02, 8'h03};
    t3_exp   = '{9'h101, 9'h102, 9'h003};
    exp_b    = 8'b0011_0011;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vin[d] = 1'b0; din[d] = 8'h00;
      m_active[d] = 1'b0; m_age[d] = 0; m_word[d] = 8'h00; m_cnt[d] = 0;
      acc_flag[d] = 1'b0;
    end
    cap_w = 8'h00; cap_n = 0;
    chk_en = 1'b1;
    step();
    step();
    chk("reset_ready", rdy_o[0], 1'b1);
    chk("reset_cnt", cnt_o[0], 8'd0);
    rst = 1'b0;

    // 1: single frame 0xA5
    send(0, 8'hA5);
    n = 0;
    while (rdy_o[0] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("t1_ready_latency", n, 10);
    chk("t1_frame", frames_q[$], 9'h0A5);
    chk("t1_cnt", cnt_o[0], 8'd1);

    // 2: parity of assorted words
    for (int i = 0; i < 4; i++) begin
      send(0, t2_words[i]);
      wait_idle(0);
      chk("t2_frame", frames_q[$], t2_exp[i]);
      chk("t2_even", $countones(frames_q[$]) % 2, 0);
    end

    // 3: back-to-back with in_valid held and in_data churned while busy
    fidx = frames_q.size();
    sidx = starts_q.size();
    vin[0] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 40; i++) begin
        din[0] = m_active[0] ? 8'($urandom) : t3_words[w];
        step();
        if (acc_flag[0]) break;
      end
    end
    vin[0] = 1'b0;
    wait_idle(0);
    chk("t3_nframes", frames_q.size() - fidx, 3);
    for (int i = 0; i < 3; i++) chk("t3_frame", frames_q[fidx + i], t3_exp[i]);
    chk("t3_period1", starts_q[sidx + 1] - starts_q[sidx], 11);
    chk("t3_period2", starts_q[sidx + 2] - starts_q[sidx + 1], 11);

    // 4: reset while data bit 4 of 0xF0 is on the line
    send(0, 8'hF0);
    for (int i = 0; i < 4; i++) step();
    fsz = frames_q.size();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_valid", val_o[0], 1'b0);
    chk("t4_busy", busy_o[0], 1'b0);
    chk("t4_ready", rdy_o[0], 1'b1);
    chk("t4_cnt", cnt_o[0], 8'd0);
    for (int i = 0; i < 6; i++) step();
    chk("t4_no_parity", frames_q.size(), fsz);
    send(0, 8'h0F);
    wait_idle(0);
    chk("t4_next_frame", frames_q[$], 9'h00F);
    chk("t4_next_cnt", cnt_o[0], 8'd1);

    // 5: frame counter wrap
    rst = 1'b1;
    step();
    rst = 1'b0;
    got = 0;
    vin[0] = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      din[0] = 8'($urandom);
      step();
      if (acc_flag[0]) got++;
      if (got == 255) break;
    end
    vin[0] = 1'b0;
    wait_idle(0);
    chk("t5_sent", got, 255);
    chk("t5_cnt255", cnt_o[0], 8'd255);
    send(0, 8'($urandom));
    wait_idle(0);
    chk("t5_wrap", cnt_o[0], 8'd0);

    // 6: DATA_W=1, GAP=0, alternating data with in_valid held
    cap_b_en = 1'b1;
    nb = 1'b1;
    got = 0;
    vin[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din[1] = m_active[1] ? 8'($urandom) : {7'd0, nb};
      step();
      if (acc_flag[1]) begin
        nb = ~nb;
        got++;
      end
      if (got == 4) break;
    end
    vin[1] = 1'b0;
    wait_idle(1);
    step();
    cap_b_en = 1'b0;
    chk("t6_nbits", b_bits.size(), 8);
    for (int i = 0; i < 8; i++) chk("t6_bit", b_bits[i], exp_b[i]);

    // Random traffic with occasional resets on both instances
    fidx = frames_q.size();
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        vin[d] = ($urandom_range(0, 2) != 0);
        din[d] = 8'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    vin[0] = 1'b0;
    vin[1] = 1'b0;
    wait_idle(0);
    for (int i = fidx; i < frames_q.size(); i++)
      chk("rand_even", $countones(frames_q[i]) % 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
